// File: rtl/multi_strobe_pkg.sv
// Shared types and helpers for the multi-channel strobe converter.
// Optional feature macro used by the converter: MULTI_STROBE_COUNT_EN.
package multi_strobe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PULSE   = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  // Counter width able to hold the larger of the pulse and hold-off reload values
  function automatic int unsigned cnt_width(input int unsigned pulse_len,
                                            input int unsigned holdoff_len);
    int unsigned m;
    m = (pulse_len > holdoff_len) ? pulse_len : holdoff_len;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/strobe_channel.sv
// One strobe channel: input synchroniser, edge detector and pulse/hold-off FSM.
// With MULTI_STROBE_COUNT_EN defined, a load strobe is exported for event counting.
module strobe_channel
  import multi_strobe_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PULSE_LEN   = 1,
  parameter int unsigned HOLDOFF_LEN = 0,
  parameter bit          RETRIGGER   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in,
  input  logic [1:0] mode,
  input  logic       clr_overrun,
  output logic       out,
  output logic       busy,
  output logic       overrun
`ifdef MULTI_STROBE_COUNT_EN
  ,
  output logic       load_evt
`endif
);

  localparam int unsigned CW         = cnt_width(PULSE_LEN, HOLDOFF_LEN);
  localparam int unsigned HOLD_INIT  = (HOLDOFF_LEN > 0) ? HOLDOFF_LEN - 1 : 0;
  localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_LEN - 1);
  localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLD_INIT);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic                   sync_last;
  logic                   rise;
  logic                   fall;
  logic                   hit;
  state_t                 state;
  state_t                 state_next;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          cnt_next;
  logic                   ovr_set;
  logic                   load;

  assign sync_last = sync[SYNC_STAGES-1];
  assign rise      = sync_last & ~prev;
  assign fall      = ~sync_last & prev;

  // Synchroniser chain and previous-sample register
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync[0] <= in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
      prev <= sync_last;
    end
  end

  // Qualify the detected edge against the channel's mode
  always_comb begin
    hit = 1'b0;
    case (mode)
      MODE_RISE: hit = rise;
      MODE_FALL: hit = fall;
      MODE_BOTH: hit = rise | fall;
      default:   hit = 1'b0;
    endcase
  end

  // State register, counter and sticky overrun (a set beats a same-cycle clear)
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      overrun <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (ovr_set) overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
    end
  end

  // Next-state logic; counter saturates at zero, load forces a pulse reload
  always_comb begin
    state_next = state;
    cnt_next   = (cnt != '0) ? cnt - 1'b1 : '0;
    ovr_set    = 1'b0;
    load       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (hit) begin
          state_next = ST_PULSE;
          load       = 1'b1;
        end
      end
      ST_PULSE: begin
        if (hit && RETRIGGER) begin
          load = 1'b1;
        end else begin
          ovr_set = hit;
          if (cnt == '0) begin
            if (HOLDOFF_LEN > 0) begin
              state_next = ST_HOLDOFF;
              cnt_next   = HOLD_LOAD;
            end else begin
              state_next = ST_IDLE;
            end
          end
        end
      end
      ST_HOLDOFF: begin
        ovr_set = hit;
        if (cnt == '0) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    if (load) cnt_next = PULSE_LOAD;
  end

  // Outputs decode straight from the state register
  always_comb begin
    out  = (state == ST_PULSE);
    busy = (state != ST_IDLE);
  end

`ifdef MULTI_STROBE_COUNT_EN
  assign load_evt = load;
`endif

endmodule

// File: rtl/multi_strobe_converter.sv
// N-channel edge-to-strobe converter: independent per-channel strobe_channel
// instances. Defining MULTI_STROBE_COUNT_EN adds per-channel event counters.
module multi_strobe_converter
  import multi_strobe_pkg::*;
#(
  parameter int unsigned N           = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PULSE_LEN   = 1,
  parameter int unsigned HOLDOFF_LEN = 0,
  parameter bit          RETRIGGER   = 1'b0,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     in,
  input  logic [2*N-1:0]   mode,
  input  logic             clr_overrun,
  output logic [N-1:0]     out,
  output logic [N-1:0]     busy,
  output logic [N-1:0]     overrun
`ifdef MULTI_STROBE_COUNT_EN
  ,
  output logic [N*CNT_W-1:0] evt_count
`endif
);

  for (genvar i = 0; i < N; i++) begin : g_ch
`ifdef MULTI_STROBE_COUNT_EN
    logic             load;
    logic [CNT_W-1:0] count;
`endif

    strobe_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .PULSE_LEN   (PULSE_LEN),
      .HOLDOFF_LEN (HOLDOFF_LEN),
      .RETRIGGER   (RETRIGGER)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .in          (in[i]),
      .mode        (mode[2*i +: 2]),
      .clr_overrun (clr_overrun),
      .out         (out[i]),
      .busy        (busy[i]),
      .overrun     (overrun[i])
`ifdef MULTI_STROBE_COUNT_EN
      ,
      .load_evt    (load)
`endif
    );

`ifdef MULTI_STROBE_COUNT_EN
    // Count accepted edges and retrigger reloads; wraps naturally
    always_ff @(posedge clk) begin
      if (rst) count <= '0;
      else if (load) count <= count + 1'b1;
    end

    assign evt_count[i*CNT_W +: CNT_W] = count;
`endif
  end

endmodule
